// File: rtl/uart_receiver_if.sv
// Byte-side and line-side signals of uart_receiver, bundled as one interface.
// The receiver uses the slave modport; the line driver and byte consumer use master.
interface uart_receiver_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  modport slave (
    input  serial_in,
    input  data_out_ready,
    output data_out,
    output data_out_valid,
    output framing_error,
    output overrun
  );

  modport master (
    output serial_in,
    output data_out_ready,
    input  data_out,
    input  data_out_valid,
    input  framing_error,
    input  overrun
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-symbol sampling, one-entry ready/valid output buffer.
// Defining UART_RX_SYNC_EN inserts a 2-flop synchronizer on serial_in (+2 cycles latency).
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.slave bus
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             prev_q;
  logic             line;
  logic             accept;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.serial_in};
  end

  assign line = sync_q[1];
`else
  assign line = bus.serial_in;
`endif

  assign accept = valid_q & bus.data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      prev_q  <= line;
    end
  end

  // A line held low never starts a frame: only a 1->0 transition leaves IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~accept;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !line) state_d = START;
      end
      START: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets the next start edge arrive with no idle gap.
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!line) begin
            ferr_d = 1'b1;
          end else if (!valid_q || accept) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out       = data_q;
  assign bus.data_out_valid = valid_q;
  assign bus.framing_error  = ferr_q;
  assign bus.overrun        = ovr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames into uart_receiver, checked against a byte-level
// model of the one-entry output buffer (delivered bytes, overruns, framing errors).
module tb_uart_receiver;
  localparam int CLOCK_FREQ = 2000;
  localparam int BAUD_RATE  = 100;
  localparam int SYM        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_DELAY = 2;
`else
  localparam int SYNC_DELAY = 0;
`endif
  localparam int LATENCY = 9 * SYM + SYM / 2 + 1 + SYNC_DELAY;

  logic clk = 1'b0;
  logic rst;

  uart_receiver_if rxIf();

  uart_receiver #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(rxIf.slave)
  );

  always #5 clk = ~clk;

  int         checkCount = 0;
  int         failCount = 0;
  int         cycle = 0;
  int         ferrSeen = 0;
  int         ovrSeen = 0;
  int         holdViolations = 0;
  int         riseCycle = 0;
  int         startCycle = 0;
  int         expFerr = 0;
  int         expOvr = 0;
  logic       modelFull;
  logic [7:0] modelData;
  logic       prevHeld = 1'b0;
  logic       prevValid = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  always @(posedge clk) cycle <= cycle + 1;

  // Observe the byte side between edges; a hold violation is any change while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prevHeld  = 1'b0;
      prevValid = 1'b0;
    end else begin
      if (prevHeld && (!rxIf.data_out_valid || rxIf.data_out !== prevData)) holdViolations++;
      if (rxIf.data_out_valid && !prevValid) riseCycle = cycle;
      if (rxIf.data_out_valid && rxIf.data_out_ready) rxQ.push_back(rxIf.data_out);
      if (rxIf.framing_error) ferrSeen++;
      if (rxIf.overrun) ovrSeen++;
      prevHeld  = rxIf.data_out_valid && !rxIf.data_out_ready;
      prevData  = rxIf.data_out;
      prevValid = rxIf.data_out_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Byte-level buffer model: one slot, drained whenever the consumer is ready.
  task automatic modelFrame(input logic [7:0] b, input logic stopBit);
    if (!stopBit) expFerr++;
    else if (rxIf.data_out_ready) expQ.push_back(b);
    else if (!modelFull) begin
      modelFull = 1'b1;
      modelData = b;
    end else expOvr++;
  endtask

  task automatic modelRelease();
    if (modelFull) begin
      expQ.push_back(modelData);
      modelFull = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    startCycle = cycle;
    rxIf.serial_in = 1'b0;
    tick(SYM);
    for (int i = 0; i < 8; i++) begin
      rxIf.serial_in = b[i];
      tick(SYM);
    end
    rxIf.serial_in = stopBit;
    tick(SYM);
    rxIf.serial_in = 1'b1;
    modelFrame(b, stopBit);
  endtask

  task automatic checkStreams(input string tag);
    checkOutput({tag, "_count"}, 32'(rxQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      checkOutput({tag, "_byte"}, 32'(rxQ[i]), 32'(expQ[i]));
    checkOutput({tag, "_ferr"}, ferrSeen, expFerr);
    checkOutput({tag, "_ovr"}, ovrSeen, expOvr);
    rxQ.delete();
    expQ.delete();
    ferrSeen = 0;
    ovrSeen  = 0;
    expFerr  = 0;
    expOvr   = 0;
  endtask

  initial begin
    logic       r;
    logic       s;
    logic [7:0] b;
    logic [7:0] abortByte;

    rst = 1'b1;
    rxIf.serial_in = 1'b1;
    rxIf.data_out_ready = 1'b0;
    modelFull = 1'b0;
    modelData = 8'h00;
    tick(4);
    checkOutput("reset_valid", 32'(rxIf.data_out_valid), 32'h0);
    checkOutput("reset_data", 32'(rxIf.data_out), 32'h0);
    checkOutput("reset_ferr", 32'(rxIf.framing_error), 32'h0);
    checkOutput("reset_ovr", 32'(rxIf.overrun), 32'h0);
    rst = 1'b0;
    tick(2 * SYM);

    rxIf.data_out_ready = 1'b1;
    applyStimulus(8'h41, 1'b1);
    tick(SYM);
    checkOutput("t1_latency", riseCycle - startCycle, LATENCY);
    checkStreams("t1");

    // Two back-to-back frames while stalled: first is held, second overruns.
    rxIf.data_out_ready = 1'b0;
    applyStimulus(8'h42, 1'b1);
    applyStimulus(8'h43, 1'b1);
    tick(SYM);
    checkOutput("t2_held_valid", 32'(rxIf.data_out_valid), 32'h1);
    checkOutput("t2_held_data", 32'(rxIf.data_out), 32'(modelData));
    rxIf.data_out_ready = 1'b1;
    modelRelease();
    tick(2);
    checkOutput("t2_valid_drop", 32'(rxIf.data_out_valid), 32'h0);
    tick(SYM);
    checkStreams("t2");

    rxIf.serial_in = 1'b0;
    tick(4);
    rxIf.serial_in = 1'b1;
    tick(2 * SYM);
    checkOutput("t3_glitch_valid", 32'(rxIf.data_out_valid), 32'h0);
    applyStimulus(8'h44, 1'b1);
    tick(SYM);
    checkStreams("t3");

    applyStimulus(8'h55, 1'b0);
    tick(SYM);
    checkOutput("t4_ferr_valid", 32'(rxIf.data_out_valid), 32'h0);
    applyStimulus(8'hA5, 1'b1);
    tick(SYM);
    checkStreams("t4");

    abortByte = 8'h5A;
    rxIf.serial_in = 1'b0;
    tick(SYM);
    for (int i = 0; i < 3; i++) begin
      rxIf.serial_in = abortByte[i];
      tick(SYM);
    end
    rxIf.serial_in = 1'b1;
    rst = 1'b1;
    tick(3);
    checkOutput("t5_reset_valid", 32'(rxIf.data_out_valid), 32'h0);
    checkOutput("t5_reset_data", 32'(rxIf.data_out), 32'h0);
    checkOutput("t5_reset_ferr", 32'(rxIf.framing_error), 32'h0);
    checkOutput("t5_reset_ovr", 32'(rxIf.overrun), 32'h0);
    rst = 1'b0;
    tick(2 * SYM);
    applyStimulus(8'h3C, 1'b1);
    tick(SYM);
    checkStreams("t5");

    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h81, 1'b1);
    tick(SYM);
    checkStreams("t6");

    for (int n = 0; n < 12; n++) begin
      r = 1'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 7) != 0);
      rxIf.data_out_ready = r;
      if (r) modelRelease();
      applyStimulus(b, s);
      tick($urandom_range(0, SYM));
    end
    rxIf.data_out_ready = 1'b1;
    modelRelease();
    tick(SYM);
    checkStreams("rand");

    checkOutput("hold_stable", holdViolations, 0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end
endmodule
